sub_blk_pingpong_collector: RTL
===============================

Name: sub_blk_pingpong_collector

Overview:
- Downstream consumer of the pipelined 16:1 sub-block take-mux.
- Each cycle it accepts one mux result (sub-block plus take flag) and places it in the next slot of a full-block assembly register.
- 16 slots are assembled per block into one of two ping-pong banks. A finished block is presented on a valid/ready output while the other bank fills.
- Untaken slots are filled with zero.

Parameters:
- SUB_BLK_W, 32, width of one sub-block (matches the codebase sub-block width).
- NUM_SUB, 16, sub-blocks per block; must be a power of two.
- SLOT_W, 4, log2(NUM_SUB); slot counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- sub_vld_i  in  1  the mux output is valid this cycle (one slot).
- take_i  in  1  the take flag from the mux, aligned with sub_i.
- sub_i  in  SUB_BLK_W  selected sub-block.
- in_rdy_o  out  1  the collector can accept a slot this cycle.
- blk_vld_o  out  1  an assembled block is available.
- blk_rdy_i  in  1  the consumer accepts the block.
- blk_o  out  NUM_SUB*SUB_BLK_W  assembled block; slot k occupies bits [k*SUB_BLK_W +: SUB_BLK_W].
- blk_bank_o  out  1  index of the bank currently driven on blk_o.

Behaviour:
- Reset (reset==0 at a clock edge):
  - slot_cnt=0, wr_bank=0, rd_bank=0, full[1:0]=0.
  - Both bank registers are cleared to 0.
  - Outputs: in_rdy_o=1, blk_vld_o=0, blk_o=0, blk_bank_o=0.
- Reset mid-block discards the partial block and any full banks. No output is produced for discarded data.
- A slot is accepted when sub_vld_i && in_rdy_o. On acceptance:
  - bank[wr_bank].slot[slot_cnt] <= take_i ? sub_i : 0.
  - slot_cnt increments.
- sub_vld_i while in_rdy_o==0: the data is dropped. Upstream must stall; this is a protocol violation for verification, not a recoverable case.
- Last slot (slot_cnt==NUM_SUB-1) accepted:
  - slot_cnt wraps to 0.
  - full[wr_bank] <= 1.
  - wr_bank toggles.
- in_rdy_o = !full[wr_bank], decoded from registered state. There is no combinational path from blk_rdy_i to in_rdy_o.
- Output side:
  - blk_vld_o = full[rd_bank].
  - blk_o = bank[rd_bank].
  - blk_bank_o = rd_bank.
  - On blk_vld_o && blk_rdy_i: full[rd_bank] <= 0 and rd_bank toggles.
- blk_o and blk_bank_o are held stable while blk_vld_o && !blk_rdy_i.
- Latency: when the last slot is accepted in cycle T, blk_vld_o=1 in cycle T+1.
- When both banks are full, in_rdy_o stays 0 until a block drains. After a drain in cycle T, in_rdy_o=1 in cycle T+1.
- Simultaneous commit (last slot into one bank) and drain (of the other bank) in the same cycle: both take effect.
- Sustained throughput is one slot per cycle. There are no bubbles when the consumer holds blk_rdy_i=1.
- Bank state per bank:
  - EMPTY/FILLING (full=0) -> FULL on last-slot accept.
  - FULL -> EMPTY on drain.
  - wr_bank and rd_bank move in strict alternation.

Optional Feature:
- Macro: SUB_BLK_COLLECT_TAKECNT_EN.
- Defined:
  - Adds output port take_cnt_o [SLOT_W:0] giving the number of taken slots in the block on blk_o (range 0..NUM_SUB).
  - The count accumulates per bank alongside the data, is latched at commit, and is held with blk_o.
  - Reset value is 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Decomposition:
- Shared package/include:
  - SUB_BLK_W, NUM_SUB and SLOT_W defaults, aligned with the codebase sub-block width macros.
  - Slot-offset helper constant.
  - Bank-index width (1).
- One natural sub-module: sub_blk_bank, a single bank with slot write-enable, zero-fill on !take, and (under the macro) the take counter. Instantiate it twice.
- Control (slot_cnt, wr/rd bank, full flags) lives in the top level.

Test Plan:
- After reset, 16 back-to-back slots with sub_i=k+1, take_i=1, blk_rdy_i=0:
  - blk_vld_o=1 one cycle after slot 15.
  - slot k of blk_o = k+1; blk_bank_o=0; in_rdy_o stays 1.
- take_i=1 only on slots 3..7, sub_i=32'hA5A5_0000+k:
  - slots 3..7 hold their data; all other slots are 0.
  - With the macro defined, take_cnt_o=5.
- 48 slots with blk_rdy_i=0 throughout:
  - after 32 slots in_rdy_o=0.
  - raise blk_rdy_i for one cycle: bank0 drains, in_rdy_o=1 the next cycle, filling resumes into bank0.
  - the second block read out is bank1's.
- Continuous input with blk_rdy_i=1:
  - one block every 16 cycles with alternating blk_bank_o.
  - no cycle with in_rdy_o=0.
  - includes a cycle where commit and drain coincide.
- Assert reset (low) after 9 slots:
  - blk_vld_o=0 and in_rdy_o=1 after the reset cycle.
  - the next 16 slots form a fresh block starting at slot 0 in bank0.
- blk_vld_o held high with blk_rdy_i=0 while the other bank fills: blk_o and blk_bank_o stay constant every cycle until accepted.

Source files
------------

// File: rtl/sub_blk_pingpong_collector_pkg.sv
// Shared widths and helpers for the ping-pong sub-block collector.
// Optional take counter is enabled with SUB_BLK_COLLECT_TAKECNT_EN.
package sub_blk_pingpong_collector_pkg;

    localparam int unsigned SubBlkW  = 32;
    localparam int unsigned NumSub   = 16;
    localparam int unsigned SlotW    = $clog2(NumSub);
    localparam int unsigned BankIdxW = 1;
    localparam int unsigned NumBanks = 2;

    typedef logic [BankIdxW-1:0] bank_idx_t;

    // Bit offset of slot k inside a flattened block.
    function automatic int unsigned slot_lsb(int unsigned k, int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/sub_blk_bank.sv
// One assembly bank: per-slot write enable with zero-fill on untaken slots.
// With SUB_BLK_COLLECT_TAKECNT_EN the bank also counts taken slots.
module sub_blk_bank
    import sub_blk_pingpong_collector_pkg::*;
#(
    parameter int unsigned SUB_BLK_W = SubBlkW,
    parameter int unsigned NUM_SUB   = NumSub,
    parameter int unsigned SLOT_W    = SlotW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we_i,
    input  logic [SLOT_W-1:0]             slot_i,
    input  logic                          take_i,
    input  logic [SUB_BLK_W-1:0]          sub_i,
    output logic [NUM_SUB*SUB_BLK_W-1:0]  data_o
`ifdef SUB_BLK_COLLECT_TAKECNT_EN
    ,
    output logic [SLOT_W:0]               take_cnt_o
`endif
);

    logic [SUB_BLK_W-1:0] slot_q [NUM_SUB];
    logic [SUB_BLK_W-1:0] slot_d [NUM_SUB];

    always_comb begin
        slot_d = slot_q;
        if (we_i) begin
            slot_d[slot_i] = take_i ? sub_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q <= '{default: '0};
        end else begin
            slot_q <= slot_d;
        end
    end

    for (genvar k = 0; k < NUM_SUB; k++) begin : g_slot
        assign data_o[slot_lsb(k, SUB_BLK_W) +: SUB_BLK_W] = slot_q[k];
    end

`ifdef SUB_BLK_COLLECT_TAKECNT_EN
    logic [SLOT_W:0] cnt_q, cnt_d;

    // Slot 0 restarts the count; the bank is not written while full, so it holds.
    always_comb begin
        cnt_d = cnt_q;
        if (we_i) begin
            if (slot_i == '0) begin
                cnt_d = {{SLOT_W{1'b0}}, take_i};
            end else begin
                cnt_d = cnt_q + {{SLOT_W{1'b0}}, take_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign take_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/sub_blk_pingpong_collector.sv
// Collects one sub-block per cycle into two ping-pong banks of NUM_SUB slots.
// Optional take_cnt_o output is enabled with SUB_BLK_COLLECT_TAKECNT_EN.
module sub_blk_pingpong_collector
    import sub_blk_pingpong_collector_pkg::*;
#(
    parameter int unsigned SUB_BLK_W = SubBlkW,
    parameter int unsigned NUM_SUB   = NumSub,
    parameter int unsigned SLOT_W    = SlotW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sub_vld_i,
    input  logic                          take_i,
    input  logic [SUB_BLK_W-1:0]          sub_i,
    output logic                          in_rdy_o,
    output logic                          blk_vld_o,
    input  logic                          blk_rdy_i,
    output logic [NUM_SUB*SUB_BLK_W-1:0]  blk_o,
    output logic                          blk_bank_o
`ifdef SUB_BLK_COLLECT_TAKECNT_EN
    ,
    output logic [SLOT_W:0]               take_cnt_o
`endif
);

    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    bank_idx_t           wr_bank_q, wr_bank_d;
    bank_idx_t           rd_bank_q, rd_bank_d;
    logic [NumBanks-1:0] full_q, full_d;

    logic accept, last_slot, drain;
    logic [NUM_SUB*SUB_BLK_W-1:0] bank_data [NumBanks];
`ifdef SUB_BLK_COLLECT_TAKECNT_EN
    logic [SLOT_W:0] bank_cnt [NumBanks];
`endif

    assign in_rdy_o  = !full_q[wr_bank_q];
    assign accept    = sub_vld_i && in_rdy_o;
    assign last_slot = accept && (slot_cnt_q == SLOT_W'(NUM_SUB - 1));
    assign drain     = full_q[rd_bank_q] && blk_rdy_i;

    // Commit and drain always hit different banks, so both updates apply.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        if (accept) begin
            slot_cnt_d = last_slot ? '0 : slot_cnt_q + 1'b1;
        end
        if (drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (last_slot) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_cnt_q <= '0;
            wr_bank_q  <= '0;
            rd_bank_q  <= '0;
            full_q     <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        sub_blk_bank #(
            .SUB_BLK_W (SUB_BLK_W),
            .NUM_SUB   (NUM_SUB),
            .SLOT_W    (SLOT_W)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .we_i       (accept && (wr_bank_q == bank_idx_t'(b))),
            .slot_i     (slot_cnt_q),
            .take_i     (take_i),
            .sub_i      (sub_i),
            .data_o     (bank_data[b])
`ifdef SUB_BLK_COLLECT_TAKECNT_EN
            ,
            .take_cnt_o (bank_cnt[b])
`endif
        );
    end

    assign blk_vld_o  = full_q[rd_bank_q];
    assign blk_o      = bank_data[rd_bank_q];
    assign blk_bank_o = rd_bank_q;
`ifdef SUB_BLK_COLLECT_TAKECNT_EN
    assign take_cnt_o = bank_cnt[rd_bank_q];
`endif

endmodule
